// File: rtl/spike_dispatcher.sv
// Input-spike FIFO feeding one LIF neuron through an IDLE/START/WAIT/RESULT handshake.
// Optional WAIT watchdog compiled in with `define SPIKE_DISPATCH_TIMEOUT_EN.
module spike_dispatcher #(
  parameter int S_WIDTH        = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [S_WIDTH-1:0]     in_data,
  output logic                          in_ready,
  output logic                          nrn_start,
  output logic signed [S_WIDTH-1:0]     nrn_spike,
  input  logic                          nrn_valid,
  input  logic                          nrn_spike_out,
  output logic                          res_valid,
  output logic                          res_spike,
  input  logic                          res_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spike_dispatcher: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic signed [S_WIDTH-1:0]   hold_q, hold_d;
  logic                        res_spike_q, res_spike_d;
  logic signed [S_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                        push, pop, wait_expired;

  assign in_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign fifo_count = count_q;
  assign nrn_spike  = hold_q;
  assign res_spike  = res_spike_q;

`ifdef SPIKE_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          terr_q, terr_d;

  // Counter restarts every time WAIT is entered; expiry forces a zero result.
  assign wait_expired = (state_q == WAIT) && !nrn_valid && (wait_cnt_q == TO_LAST);

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == WAIT) wait_cnt_d = wait_cnt_q + TW'(1);
    terr_d = terr_q | wait_expired;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      terr_q     <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      terr_q     <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign wait_expired = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      res_spike_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      res_spike_q <= res_spike_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = hold_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      hold_d   = mem_q[rd_ptr_q];
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    res_spike_d = res_spike_q;
    if (state_q == WAIT) begin
      if (nrn_valid)         res_spike_d = nrn_spike_out;
      else if (wait_expired) res_spike_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (nrn_valid || wait_expired) state_d = RESULT;
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nrn_start = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      START:   nrn_start = 1'b1;
      RESULT:  res_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
